// File: rtl/fetch_unit.sv
// fetch_unit: issues word-aligned instruction fetches,
// buffers up to two {pc, instr} entries for decode.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   next_pc_i           redirect target (low bits ignored)
//   redirect_i          take next_pc_i, flush buffer
//   imem_req_o          fetch request valid
//   imem_addr_o         fetch address (word aligned)
//   imem_gnt_i          memory accepts request
//   imem_rvalid_i       in-order response valid
//   imem_rdata_i        response instruction word
//   if_valid_o          head entry available
//   if_instr_o          head instruction
//   if_pc_o             head pc
//   pc_plus4_o          head pc + 4
//   if_ready_i          decode consumes head
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] next_pc_i,
    input  logic        redirect_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] pc_plus4_o,
    input  logic        if_ready_i
);

    logic [31:0] fetch_pc;
    logic [31:0] buf_pc    [2];
    logic [31:0] buf_instr [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic [1:0]  outstanding;
    logic [1:0]  drop;

    logic [2:0]  budget;
    logic        accept;
    logic        rsp_used;
    logic        push;
    logic        pop;
    logic [31:0] rsp_pc;
    logic [1:0]  drop_redir;

    // Buffer slots are reserved for every in-flight
    // request, including ones that will be dropped.
    assign budget = {1'b0, count}
                  + {1'b0, outstanding}
                  + {1'b0, drop};

    assign imem_req_o  = rst_n & ~redirect_i
                       & (budget < 3'd2);
    assign imem_addr_o = fetch_pc;
    assign accept      = imem_req_o & imem_gnt_i;

    assign rsp_used = imem_rvalid_i
                    & ((drop != 2'd0)
                    | (outstanding != 2'd0));

    assign push = imem_rvalid_i & ~redirect_i
                & (drop == 2'd0)
                & (outstanding != 2'd0);

    assign pop = if_valid_o & if_ready_i & ~redirect_i;

    // Live requests are contiguous and end at
    // fetch_pc - 4, so the oldest one sits
    // outstanding words behind fetch_pc.
    assign rsp_pc = fetch_pc
                  - {28'd0, outstanding, 2'b00};

    // A response arriving with the redirect retires
    // one stale request, so it is not re-counted.
    assign drop_redir = drop + outstanding
                      - {1'b0, rsp_used};

    assign if_valid_o = (count != 2'd0);
    assign if_pc_o    = buf_pc[rd_ptr];
    assign if_instr_o = buf_instr[rd_ptr];
    assign pc_plus4_o = if_pc_o + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc     <= {RESET_PC[31:2], 2'b00};
            buf_pc[0]    <= 32'd0;
            buf_pc[1]    <= 32'd0;
            buf_instr[0] <= 32'd0;
            buf_instr[1] <= 32'd0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            count        <= 2'd0;
            outstanding  <= 2'd0;
            drop         <= 2'd0;
        end else if (redirect_i) begin
            fetch_pc    <= {next_pc_i[31:2], 2'b00};
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
            outstanding <= 2'd0;
            drop        <= drop_redir;
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (imem_rvalid_i && drop != 2'd0) begin
                drop <= drop - 2'd1;
            end
            outstanding <= outstanding
                         + {1'b0, accept}
                         - {1'b0, push};
            count <= count
                   + {1'b0, push}
                   - {1'b0, pop};
            if (push) begin
                buf_pc[wr_ptr]    <= rsp_pc;
                buf_instr[wr_ptr] <= imem_rdata_i;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch traffic against an
// epoch-based reference model with a scoreboard.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] next_pc_i = 32'd0;
    logic        redirect_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'd0;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic [31:0] pc_plus4_o;
    logic        if_ready_i = 1'b0;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .next_pc_i    (next_pc_i),
        .redirect_i   (redirect_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .if_valid_o   (if_valid_o),
        .if_instr_o   (if_instr_o),
        .if_pc_o      (if_pc_o),
        .pc_plus4_o   (pc_plus4_o),
        .if_ready_i   (if_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    pend_t       pending [$];
    exp_t        sb [$];
    logic [31:0] pops_log [$];
    logic [31:0] model_pc = RPC;
    int          epoch = 0;
    int          reset_epoch = 0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          p_gnt = 100;
    int          p_rsp = 100;
    int          p_rdy = 100;
    int          p_redir = 0;

    function automatic logic [31:0] memf(
        input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h @%0t",
                     name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, check the request
    // side, then advance the reference model.
    task automatic step(input bit fr,
                        input logic [31:0] tgt,
                        input bit rst);
        bit    rsp_now;
        bit    ereq;
        int    inflight;
        pend_t r;
        @(negedge clk);
        rst_n = ~rst;
        imem_gnt_i = ($urandom_range(99) < p_gnt);
        rsp_now = rst_n && pending.size() != 0
               && pending[0].due <= cyc
               && ($urandom_range(99) < p_rsp);
        imem_rvalid_i = rsp_now;
        imem_rdata_i = rsp_now ? memf(pending[0].addr)
                               : $urandom();
        if_ready_i = ($urandom_range(99) < p_rdy);
        redirect_i = rst_n &&
            (fr || ($urandom_range(99) < p_redir));
        next_pc_i = fr ? tgt : $urandom();
        #1;
        inflight = 0;
        foreach (pending[i])
            if (pending[i].epoch >= reset_epoch)
                inflight++;
        ereq = rst_n && !redirect_i
            && (sb.size() + inflight < 2);
        chk("imem_req", {31'd0, imem_req_o},
            {31'd0, ereq});
        if (ereq)
            chk("imem_addr", imem_addr_o, model_pc);
        #2;
        if (!rst_n) begin
            epoch++;
            reset_epoch = epoch;
            sb.delete();
            model_pc = RPC;
        end else begin
            if (rsp_now) begin
                r = pending.pop_front();
                if (r.epoch == epoch && !redirect_i)
                    sb.push_back('{r.addr, memf(r.addr)});
            end
            if (ereq && imem_gnt_i) begin
                pending.push_back(
                    '{model_pc, epoch, cyc + 1});
                model_pc = model_pc + 32'd4;
            end
            if (redirect_i) begin
                epoch++;
                sb.delete();
                model_pc = {next_pc_i[31:2], 2'b00};
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    task automatic drain();
        bit done;
        p_gnt = 0;
        p_rsp = 100;
        p_rdy = 100;
        p_redir = 0;
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            step(0, 0, 0);
            done = (pending.size() == 0)
                && (sb.size() == 0);
        end
        chk("drain_done", {31'd0, done}, 32'd1);
    endtask

    // Monitor: compares the presented head and pops
    // the scoreboard on each consumed instruction.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst_n) begin
            chk("rst_valid", {31'd0, if_valid_o}, 0);
            chk("rst_pc", if_pc_o, 32'd0);
            chk("rst_instr", if_instr_o, 32'd0);
            chk("rst_plus4", pc_plus4_o, 32'd4);
        end else begin
            chk("if_valid", {31'd0, if_valid_o},
                {31'd0, sb.size() != 0});
            if (if_valid_o && sb.size() != 0) begin
                e = sb[0];
                chk("if_pc", if_pc_o, e.pc);
                chk("if_instr", if_instr_o, e.instr);
                chk("pc_plus4", pc_plus4_o,
                    e.pc + 32'd4);
                if (if_ready_i && !redirect_i) begin
                    void'(sb.pop_front());
                    pops_log.push_back(e.pc);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: no finish by %0t",
                 $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] first_pc;
        // reset, then full-rate streaming
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        pops_log.delete();
        run(15);
        chk("s1_pops", {31'd0, pops_log.size() >= 3},
            32'd1);
        if (pops_log.size() >= 3) begin
            chk("s1_pc0", pops_log[0], 32'h0);
            chk("s1_pc1", pops_log[1], 32'h4);
            chk("s1_pc2", pops_log[2], 32'h8);
        end

        // decode stalled: buffer fills, fetch stops
        drain();
        first_pc = model_pc;
        p_gnt = 100;
        p_rdy = 0;
        pops_log.delete();
        run(8);
        @(posedge clk);
        #1;
        chk("s2_valid", {31'd0, if_valid_o}, 32'd1);
        chk("s2_req", {31'd0, imem_req_o}, 32'd0);
        chk("s2_head", if_pc_o, first_pc);
        p_rdy = 100;
        run(10);
        chk("s2_pops", {31'd0, pops_log.size() >= 2},
            32'd1);
        if (pops_log.size() >= 2) begin
            chk("s2_pc0", pops_log[0], first_pc);
            chk("s2_pc1", pops_log[1],
                first_pc + 32'd4);
        end

        // redirect with two requests outstanding
        drain();
        p_gnt = 100;
        p_rsp = 0;
        run(4);
        pops_log.delete();
        step(1, 32'h0000_0103, 0);
        @(posedge clk);
        #1;
        chk("s3_addr", imem_addr_o, 32'h100);
        p_rsp = 100;
        run(10);
        chk("s3_pops", {31'd0, pops_log.size() >= 1},
            32'd1);
        if (pops_log.size() >= 1)
            chk("s3_first", pops_log[0], 32'h100);

        // redirect alongside a response and a pop
        drain();
        p_gnt = 100;
        p_rsp = 0;
        p_rdy = 0;
        run(2);
        p_gnt = 0;
        p_rsp = 100;
        run(1);
        p_rdy = 100;
        pops_log.delete();
        step(1, 32'h0000_0200, 0);
        @(posedge clk);
        #1;
        chk("s4_empty", {31'd0, if_valid_o}, 32'd0);
        chk("s4_addr", imem_addr_o, 32'h200);
        p_gnt = 100;
        run(10);
        chk("s4_pops", {31'd0, pops_log.size() >= 1},
            32'd1);
        if (pops_log.size() >= 1)
            chk("s4_first", pops_log[0], 32'h200);

        // address wrap at top of memory
        drain();
        p_gnt = 100;
        pops_log.delete();
        step(1, 32'hFFFF_FFFC, 0);
        run(10);
        chk("s5_pops", {31'd0, pops_log.size() >= 2},
            32'd1);
        if (pops_log.size() >= 2) begin
            chk("s5_pc0", pops_log[0], 32'hFFFF_FFFC);
            chk("s5_pc1", pops_log[1], 32'h0);
        end

        // reset with one request in flight
        drain();
        p_gnt = 100;
        p_rsp = 0;
        run(1);
        p_gnt = 0;
        step(0, 0, 1);
        step(0, 0, 1);
        p_rsp = 100;
        for (int i = 0; i < 20 && pending.size() != 0;
             i++)
            step(0, 0, 0);
        chk("s6_stray", {31'd0, pending.size() == 0},
            32'd1);
        chk("s6_addr", imem_addr_o, RPC);
        p_gnt = 100;
        pops_log.delete();
        run(10);
        chk("s6_pops", {31'd0, pops_log.size() >= 1},
            32'd1);
        if (pops_log.size() >= 1)
            chk("s6_first", pops_log[0], RPC);

        // randomized traffic with redirects
        for (int seg = 0; seg < 20; seg++) begin
            p_gnt = $urandom_range(100, 30);
            p_rsp = $urandom_range(100, 30);
            p_rdy = $urandom_range(100, 20);
            p_redir = $urandom_range(12);
            run(100);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
